seg_glyph_reader: RTL and testbench

Sequential seven-segment glyph reader for the lab display path. It accepts a stream of active-low segment patterns over a valid/ready handshake, one digit per transfer, most significant digit first, and converts each glyph back to its 4-bit hex value. After NUM_DIGITS digits it presents the assembled multi-digit value through a single-entry valid/ready output buffer. It also flags frames containing unrecognised glyphs and keeps a saturating error count, so benches and on-board checkers can read display drive back as numbers.

---
 rtl/seg_glyph_reader.sv | 128 ++++++++++++
 tb/tb_seg_glyph_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_glyph_reader.sv
// Reads back active-low seven-segment glyphs one digit per transfer and
// assembles NUM_DIGITS hex nibbles into a frame behind a one-entry output buffer.

module seg_glyph_dec #(
  parameter bit BLANK_AS_ZERO = 1'b1
) (
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_inv
);
  always_comb begin
    o_nib = 4'h0;
    o_inv = 1'b0;
    case (i_seg)
      7'h40: o_nib = 4'h0;
      7'h79: o_nib = 4'h1;
      7'h24: o_nib = 4'h2;
      7'h30: o_nib = 4'h3;
      7'h19: o_nib = 4'h4;
      7'h12: o_nib = 4'h5;
      7'h02: o_nib = 4'h6;
      7'h78: o_nib = 4'h7;
      7'h00: o_nib = 4'h8;
      7'h10: o_nib = 4'h9;
      7'h08: o_nib = 4'hA;
      7'h03: o_nib = 4'hB;
      7'h46: o_nib = 4'hC;
      7'h21: o_nib = 4'hD;
      7'h06: o_nib = 4'hE;
      7'h0E: o_nib = 4'hF;
      7'h7F: o_inv = !BLANK_AS_ZERO;
      default: o_inv = 1'b1;
    endcase
  end
endmodule

module seg_glyph_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter bit BLANK_AS_ZERO = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [6:0]              i_seg_in,
  input  logic                    i_seg_valid,
  output logic                    o_seg_ready,
  output logic [4*NUM_DIGITS-1:0] o_value_out,
  output logic                    o_value_valid,
  input  logic                    i_value_ready,
  output logic                    o_frame_err,
  output logic [7:0]              o_err_count
);
  localparam int         W    = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_cnt;
  logic [W-1:0]   r_shift, r_value, w_shift_nxt;
  logic           r_ferr, r_vferr;
  logic [7:0]     r_err_cnt;
  logic [3:0]     w_nib;
  logic           w_inv, w_accept, w_last;

  seg_glyph_dec #(.BLANK_AS_ZERO(BLANK_AS_ZERO)) u_dec (
    .i_seg (i_seg_in),
    .o_nib (w_nib),
    .o_inv (w_inv)
  );

  // Single-digit frames have nothing to shift; the new nibble is the frame.
  generate
    if (NUM_DIGITS == 1) begin : g_one
      assign w_shift_nxt = w_nib;
    end else begin : g_many
      assign w_shift_nxt = {r_shift[W-5:0], w_nib};
    end
  endgenerate

  assign w_accept = i_seg_valid && (r_state == COLLECT);
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_accept && w_last) w_state_nxt = FULL;
      FULL:    if (i_value_ready)      w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_value   <= '0;
      r_ferr    <= 1'b0;
      r_vferr   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= w_shift_nxt;
        r_ferr  <= r_ferr | w_inv;
        if (w_inv && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        if (w_last) begin
          r_cnt   <= '0;
          r_value <= w_shift_nxt;
          r_vferr <= r_ferr | w_inv;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
      // The running flag stays set until the held frame is taken.
      if (r_state == FULL && i_value_ready) r_ferr <= 1'b0;
    end
  end

  assign o_seg_ready   = (r_state == COLLECT);
  assign o_value_valid = (r_state == FULL);
  assign o_value_out   = r_value;
  assign o_frame_err   = r_vferr;
  assign o_err_count   = r_err_cnt;
endmodule

// File: tb/tb_seg_glyph_reader.sv
// Scoreboard bench: a driver feeds glyphs and pushes expected frames from a
// table-lookup model; a monitor pops and compares whenever a frame is shown.

module tb_seg_glyph_reader;
  localparam int N = 4;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic [6:0]    i_seg_in = '0;
  logic          i_seg_valid = 1'b0, i_value_ready = 1'b0;
  logic          rdy1, vld1, fe1, rdy0, vld0, fe0;
  logic [4*N-1:0] val1, val0;
  logic [7:0]    ec1, ec0;

  seg_glyph_reader #(.NUM_DIGITS(N), .BLANK_AS_ZERO(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_seg_in(i_seg_in), .i_seg_valid(i_seg_valid),
    .o_seg_ready(rdy1), .o_value_out(val1), .o_value_valid(vld1),
    .i_value_ready(i_value_ready), .o_frame_err(fe1), .o_err_count(ec1));

  seg_glyph_reader #(.NUM_DIGITS(N), .BLANK_AS_ZERO(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_seg_in(i_seg_in), .i_seg_valid(i_seg_valid),
    .o_seg_ready(rdy0), .o_value_out(val0), .o_value_valid(vld0),
    .i_value_ready(i_value_ready), .o_frame_err(fe0), .o_err_count(ec0));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4*N-1:0] v;
    bit fe1, fe0;
    int ec1, ec0;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state
  int m_cnt = 0, m_ec1 = 0, m_ec0 = 0;
  longint m_val = 0;
  bit m_fe1 = 0, m_fe0 = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic model_digit(input logic [6:0] p);
    int d;
    bit inv1, inv0;
    exp_t e;
    d = lookup(p);
    inv0 = (d < 0);
    inv1 = (d < 0) && (p != 7'h7F);
    if (d < 0) d = 0;
    m_val = m_val * 16 + d;
    m_fe1 |= inv1;
    m_fe0 |= inv0;
    if (inv1 && m_ec1 < 255) m_ec1++;
    if (inv0 && m_ec0 < 255) m_ec0++;
    m_cnt++;
    if (m_cnt == N) begin
      e.v = m_val[4*N-1:0]; e.fe1 = m_fe1; e.fe0 = m_fe0; e.ec1 = m_ec1; e.ec0 = m_ec0;
      q.push_back(e);
      m_cnt = 0; m_val = 0; m_fe1 = 0; m_fe0 = 0;
    end
  endtask

  task automatic send(input logic [6:0] p);
    bit done = 0;
    @(negedge i_clk);
    i_seg_in = p;
    i_seg_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (rdy1) begin
        @(posedge i_clk);
        done = 1;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: seg_ready stayed %0d, expected 1", rdy1);
    end else begin
      model_digit(p);
    end
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    i_seg_valid = 1'b0;
    i_seg_in = 7'($urandom);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic rand_glyph(output logic [6:0] p);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       p = glyph[$urandom_range(0, 15)];
    else if (r == 7) p = 7'h7F;
    else             p = 7'($urandom);
  endtask

  // consumer
  always @(posedge i_clk) begin
    #2;
    case (ready_mode)
      0: i_value_ready = 1'b1;
      1: i_value_ready = 1'($urandom);
      default: i_value_ready = 1'b0;
    endcase
  end

  // monitor
  bit presented = 0;
  exp_t cur;
  always @(negedge i_clk) begin
    if (i_rst) begin
      presented = 0;
    end else if (vld1) begin
      if (!presented) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: value %0h with no frame expected", val1);
        end else begin
          cur = q.pop_front();
          chk("value_out", val1, cur.v);
          chk("frame_err", fe1, cur.fe1);
          chk("err_count", ec1, cur.ec1);
          chk("value_out_noblank", val0, cur.v);
          chk("frame_err_noblank", fe0, cur.fe0);
          chk("err_count_noblank", ec0, cur.ec0);
          chk("valid_noblank", vld0, 1);
        end
        presented = 1;
      end else begin
        chk("value_hold", val1, cur.v);
        chk("ferr_hold", fe1, cur.fe1);
      end
      if (i_value_ready) presented = 0;
    end
  end

  initial begin
    logic [6:0] p;
    logic [6:0] seq1 [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    logic [6:0] seqb [4] = '{7'h40, 7'h7F, 7'h5A, 7'h00};
    logic [6:0] seqr [4] = '{7'h12, 7'h02, 7'h78, 7'h00};

    #12;
    chk("rst_ready", rdy1, 1);
    chk("rst_valid", vld1, 0);
    chk("rst_value", val1, 0);
    chk("rst_ferr", fe1, 0);
    chk("rst_errcnt", ec1, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // basic frame and latency
    for (int i = 0; i < 4; i++) send(seq1[i]);
    @(negedge i_clk);
    chk("valid_after_last", vld1, 1);
    chk("ready_low_full", rdy1, 0);
    chk("frame_1234", val1, 16'h1234);
    idle(2);

    // all 16 glyphs in order
    for (int i = 0; i < 16; i++) send(glyph[i]);
    idle(2);

    // blank / invalid frame
    for (int i = 0; i < 4; i++) send(seqb[i]);
    idle(2);
    chk("blank_errcnt", ec1, 1);
    chk("blank_errcnt_noblank", ec0, 2);

    // hold output for 10 cycles with source waiting
    ready_mode = 2;
    for (int i = 0; i < 4; i++) send(glyph[(i * 5) % 16]);
    @(negedge i_clk);
    i_seg_in = glyph[9];
    i_seg_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk("hold_ready_low", rdy1, 0);
      chk("hold_valid", vld1, 1);
    end
    ready_mode = 0;
    send(glyph[9]);
    for (int i = 0; i < 3; i++) send(glyph[i + 10]);
    idle(2);

    // reset after 2 digits
    send(seq1[0]);
    send(seq1[1]);
    @(negedge i_clk);
    i_seg_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("midrst_ready", rdy1, 1);
    chk("midrst_valid", vld1, 0);
    chk("midrst_value", val1, 0);
    chk("midrst_ferr", fe1, 0);
    chk("midrst_errcnt", ec1, 0);
    q.delete();
    m_cnt = 0; m_val = 0; m_fe1 = 0; m_fe0 = 0; m_ec1 = 0; m_ec0 = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) send(seqr[i]);
    @(negedge i_clk);
    chk("post_rst_5678", val1, 16'h5678);
    idle(1);

    // random frames with random gaps and back-pressure
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        rand_glyph(p);
        send(p);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    ready_mode = 0;

    // error counter saturation
    for (int i = 0; i < 260; i++) send(7'h55);
    idle(3);
    chk("sat_errcnt", ec1, 255);
    chk("sat_errcnt_noblank", ec0, 255);

    for (int c = 0; c < 100 && q.size() != 0; c++) @(negedge i_clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
